// File: rtl/pc_seq_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : pc_seq_unit                                                    |
// | Purpose  : Program-counter sequencer: fetch/commit handshakes, next-PC    |
// |            selection, trap redirect, misalign detect, instret counter.    |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module pc_seq_unit #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = 32'h8000_0000,
    parameter int               ILEN_BYTES = 4,
    parameter int               CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    input  logic             pc_ready,
    input  logic             commit_valid,
    input  logic [1:0]       pc_src,
    input  logic [XLEN-1:0]  ext_imm,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             br_taken,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vec,
    output logic             redirect,
    output logic             misalign,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] c_STEP       = XLEN'(ILEN_BYTES);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             redirect_q, redirect_d;
    logic             misalign_q, misalign_d;

    logic [XLEN-1:0]  w_seq_pc;
    logic [XLEN-1:0]  w_target;
    logic             w_misaligned;

    assign w_seq_pc = pc_q + c_STEP;

    always_comb begin
        w_target = w_seq_pc;
        case (pc_src)
            2'b00:   w_target = w_seq_pc;
            2'b01:   w_target = pc_q + ext_imm;
            2'b10:   w_target = alu_result & ~{{(XLEN-1){1'b0}}, 1'b1};
            default: w_target = br_taken ? (pc_q + ext_imm) : w_seq_pc;
        endcase
    end

    assign w_misaligned = |(w_target & c_ALIGN_MASK);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instret_d  = instret_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            S_HOLD: state_d = S_FETCH;
            S_FETCH: begin
                // A trap abandons any fetch handshake happening this cycle.
                if (trap_valid) begin
                    pc_d       = trap_vec;
                    redirect_d = 1'b1;
                end else if (pc_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (trap_valid) begin
                    pc_d       = trap_vec;
                    redirect_d = 1'b1;
                    state_d    = S_FETCH;
                end else if (commit_valid) begin
                    instret_d = instret_q + 1'b1;
                    state_d   = S_FETCH;
                    if (w_misaligned) begin
                        pc_d       = trap_vec;
                        misalign_d = 1'b1;
                        redirect_d = 1'b1;
                    end else begin
                        pc_d       = w_target;
                        redirect_d = (w_target != w_seq_pc);
                    end
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HOLD;
            pc_q       <= RESET_PC;
            instret_q  <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instret_q  <= instret_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == S_FETCH);
    assign redirect = redirect_q;
    assign misalign = misalign_q;
    assign instret  = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_pc_seq_unit                                                 |
// | Purpose  : Directed self-checking bench for pc_seq_unit.                  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_ready, commit_valid, br_taken, trap_valid;
    logic [1:0]  pc_src;
    logic [31:0] ext_imm, alu_result, trap_vec;

    logic [31:0] pc, pc2;
    logic        pc_valid, pc_valid2;
    logic        redirect, redirect2, misalign, misalign2;
    logic [63:0] instret, instret2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_seq_unit u_dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .commit_valid(commit_valid), .pc_src(pc_src), .ext_imm(ext_imm),
        .alu_result(alu_result), .br_taken(br_taken), .trap_valid(trap_valid),
        .trap_vec(trap_vec), .redirect(redirect), .misalign(misalign),
        .instret(instret)
    );

    // Same stimulus, 2-byte instruction alignment.
    pc_seq_unit #(.ILEN_BYTES(2)) u_dut2 (
        .clk(clk), .rst(rst), .pc(pc2), .pc_valid(pc_valid2), .pc_ready(pc_ready),
        .commit_valid(commit_valid), .pc_src(pc_src), .ext_imm(ext_imm),
        .alu_result(alu_result), .br_taken(br_taken), .trap_valid(trap_valid),
        .trap_vec(trap_vec), .redirect(redirect2), .misalign(misalign2),
        .instret(instret2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while in FETCH; returns at the negedge after commit.
    task automatic do_instr(input logic [1:0] src, input logic [31:0] imm,
                            input logic [31:0] alu, input logic bt);
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready = 1'b0;
        chk("exec_pc_valid", {63'd0, pc_valid}, 64'd0);
        commit_valid = 1'b1;
        pc_src       = src;
        ext_imm      = imm;
        alu_result   = alu;
        br_taken     = bt;
        @(negedge clk);
        commit_valid = 1'b0;
        pc_src       = 2'b00;
        br_taken     = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc,
                               input logic e_redir, input logic e_mis, input logic [63:0] e_ret);
        chk({tag, "_pc"},       {32'd0, pc}, {32'd0, e_pc});
        chk({tag, "_redirect"}, {63'd0, redirect}, {63'd0, e_redir});
        chk({tag, "_misalign"}, {63'd0, misalign}, {63'd0, e_mis});
        chk({tag, "_instret"},  instret, e_ret);
        chk({tag, "_pc_valid"}, {63'd0, pc_valid}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; pc_ready = 1'b0; commit_valid = 1'b0; br_taken = 1'b0;
        trap_valid = 1'b0; pc_src = 2'b00; ext_imm = '0; alu_result = '0;
        trap_vec = 32'h8000_1000;

        repeat (2) @(negedge clk);
        chk("rst_pc",       {32'd0, pc}, 64'h8000_0000);
        chk("rst_pc_valid", {63'd0, pc_valid}, 64'd0);
        chk("rst_instret",  instret, 64'd0);
        chk("rst_redirect", {63'd0, redirect}, 64'd0);
        rst = 1'b0;
        #1 chk("hold_pc_valid", {63'd0, pc_valid}, 64'd0);
        @(negedge clk);
        chk("fetch_pc_valid", {63'd0, pc_valid}, 64'd1);

        // commit outside EXEC is ignored
        commit_valid = 1'b1;
        @(negedge clk);
        commit_valid = 1'b0;
        chk("ign_commit_pc", {32'd0, pc}, 64'h8000_0000);
        chk("ign_commit_ret", instret, 64'd0);

        do_instr(2'b00, 32'h0, 32'h0, 1'b0);
        check_state("seq", 32'h8000_0004, 1'b0, 1'b0, 64'd1);
        repeat (3) do_instr(2'b00, 32'h0, 32'h0, 1'b0);
        chk("seq3_pc", {32'd0, pc}, 64'h8000_0010);

        do_instr(2'b11, 32'hFFFF_FFF0, 32'h0, 1'b1);
        check_state("br_t", 32'h8000_0000, 1'b1, 1'b0, 64'd5);
        repeat (4) do_instr(2'b00, 32'h0, 32'h0, 1'b0);
        do_instr(2'b11, 32'hFFFF_FFF0, 32'h0, 1'b0);
        check_state("br_nt", 32'h8000_0014, 1'b0, 1'b0, 64'd10);

        do_instr(2'b01, 32'h0000_0020, 32'h0, 1'b0);
        check_state("jal", 32'h8000_0034, 1'b1, 1'b0, 64'd11);

        do_instr(2'b10, 32'h0, 32'h8000_0103, 1'b0);
        check_state("jalr_mis", 32'h8000_1000, 1'b1, 1'b1, 64'd12);
        chk("jalr2_pc",       {32'd0, pc2}, 64'h8000_0102);
        chk("jalr2_misalign", {63'd0, misalign2}, 64'd0);

        // trap in FETCH beats a simultaneous fetch handshake
        trap_vec = 32'h8000_2000; trap_valid = 1'b1; pc_ready = 1'b1;
        @(negedge clk);
        trap_valid = 1'b0; pc_ready = 1'b0;
        check_state("trap_f", 32'h8000_2000, 1'b1, 1'b0, 64'd12);
        @(negedge clk);
        chk("trap_f_pulse", {63'd0, redirect}, 64'd0);

        // trap in EXEC beats a simultaneous commit
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready = 1'b0;
        trap_vec = 32'h8000_3000; trap_valid = 1'b1; commit_valid = 1'b1;
        @(negedge clk);
        trap_valid = 1'b0; commit_valid = 1'b0;
        check_state("trap_e", 32'h8000_3000, 1'b1, 1'b0, 64'd12);

        do_instr(2'b10, 32'h0, 32'hFFFF_FFFC, 1'b0);
        check_state("jalr_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 64'd13);
        do_instr(2'b00, 32'h0, 32'h0, 1'b0);
        check_state("wrap", 32'h0000_0000, 1'b0, 1'b0, 64'd14);

        // asynchronous reset in the middle of EXEC
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_pc",       {32'd0, pc}, 64'h8000_0000);
        chk("arst_instret",  instret, 64'd0);
        chk("arst_pc_valid", {63'd0, pc_valid}, 64'd0);
        @(negedge clk);
        // trap during HOLD is ignored
        trap_valid = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        trap_valid = 1'b0;
        chk("hold_trap_pc",       {32'd0, pc}, 64'h8000_0000);
        chk("hold_trap_redirect", {63'd0, redirect}, 64'd0);
        chk("hold_trap_pc_valid", {63'd0, pc_valid}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
